rf_wb_arb: RTL and testbench

//  Owns the single write port of the 32x32 register file (rf).

---
 rtl/rf_pkg.sv | 16 +
 rtl/rf_wb_arb_if.sv | 36 +++
 rtl/rf_wb_arb_rr_arb.sv | 31 +++
 rtl/rf_wb_arb.sv | 80 ++++++++
 tb/tb_rf_wb_arb.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared widths, requester ids and round-robin helper for rf write-back
package rf_pkg;

    localparam int XLEN    = 32;
    localparam int AW      = 5;
    localparam int N_REQ   = 3;

    localparam int REQ_ALU = 0;
    localparam int REQ_MUL = 1;
    localparam int REQ_LSU = 2;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rf_wb_arb_if.sv
// rtl/rf_wb_arb_if.sv - write-back request, rf write and scoreboard lookup bundle
interface rf_wb_arb_if #(
    parameter int N_REQ = rf_pkg::N_REQ,
    parameter int XLEN  = rf_pkg::XLEN,
    parameter int AW    = rf_pkg::AW
);
    logic [N_REQ-1:0]      wb_req_vld;
    logic [N_REQ*AW-1:0]   wb_req_addr;
    logic [N_REQ*XLEN-1:0] wb_req_data;
    logic [N_REQ-1:0]      wb_req_rdy;

    logic                  rf_wb_vld;
    logic [AW-1:0]         rf_wb_addr;
    logic [XLEN-1:0]       rf_wb_data;

    logic                  idu_sb_set_vld;
    logic [AW-1:0]         idu_sb_set_addr;
    logic                  idu_sb_flush;
    logic [AW-1:0]         idu_src1_addr;
    logic [AW-1:0]         idu_src2_addr;
    logic                  sb_src1_busy;
    logic                  sb_src2_busy;

    modport master (
        output wb_req_vld, wb_req_addr, wb_req_data,
        output idu_sb_set_vld, idu_sb_set_addr, idu_sb_flush, idu_src1_addr, idu_src2_addr,
        input  wb_req_rdy, rf_wb_vld, rf_wb_addr, rf_wb_data, sb_src1_busy, sb_src2_busy
    );

    modport slave (
        input  wb_req_vld, wb_req_addr, wb_req_data,
        input  idu_sb_set_vld, idu_sb_set_addr, idu_sb_flush, idu_src1_addr, idu_src2_addr,
        output wb_req_rdy, rf_wb_vld, rf_wb_addr, rf_wb_data, sb_src1_busy, sb_src2_busy
    );

endinterface

// File: rtl/rf_wb_arb_rr_arb.sv
// rtl/rf_wb_arb_rr_arb.sv - combinational round-robin arbiter, search starts at i_ptr
module rr_arb #(
    parameter int N = 3,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_vld,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_gnt_idx,
    output logic          o_any
);

    int w_idx;

    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_any     = 1'b0;
        w_idx     = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = int'(i_ptr) + k;
            if (w_idx >= N) w_idx = w_idx - N;
            if (!o_any && i_vld[w_idx]) begin
                o_any        = 1'b1;
                o_gnt[w_idx] = 1'b1;
                o_gnt_idx    = IW'(w_idx);
            end
        end
    end

endmodule

// File: rtl/rf_wb_arb.sv
// rtl/rf_wb_arb.sv - rf write-port owner: round-robin write-back arbiter plus RAW scoreboard
module rf_wb_arb
    import rf_pkg::*;
#(
    parameter int N_REQ = rf_pkg::N_REQ,
    parameter int XLEN  = rf_pkg::XLEN,
    parameter int AW    = rf_pkg::AW
) (
    input  logic         clk,
    input  logic         rst_n,
    rf_wb_arb_if.slave   bus
);

    localparam int IW   = $clog2(N_REQ);
    localparam int NREG = 1 << AW;

    logic [N_REQ-1:0] w_gnt;
    logic [IW-1:0]    w_gnt_idx;
    logic             w_gnt_any;
    logic [AW-1:0]    w_req_addr;
    logic [XLEN-1:0]  w_req_data;
    logic [NREG-1:0]  w_sb_nxt;

    logic [IW-1:0]    r_rr_ptr;
    logic             r_wb_vld;
    logic [AW-1:0]    r_wb_addr;
    logic [XLEN-1:0]  r_wb_data;
    logic [NREG-1:0]  r_sb;

    rr_arb #(.N(N_REQ)) u_rr_arb (
        .i_vld     (bus.wb_req_vld),
        .i_ptr     (r_rr_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_any     (w_gnt_any)
    );

    assign w_req_addr = bus.wb_req_addr[int'(w_gnt_idx)*AW +: AW];
    assign w_req_data = bus.wb_req_data[int'(w_gnt_idx)*XLEN +: XLEN];

    assign bus.wb_req_rdy = rst_n ? '0 : w_gnt;

    // x0 writes are accepted from the requester but never reach rf
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_rr_ptr  <= '0;
            r_wb_vld  <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
        end else if (w_gnt_any) begin
            r_rr_ptr  <= IW'(rr_next(int'(w_gnt_idx), N_REQ));
            r_wb_vld  <= (w_req_addr != '0);
            r_wb_addr <= w_req_addr;
            r_wb_data <= w_req_data;
        end else begin
            r_wb_vld  <= 1'b0;
        end
    end

    assign bus.rf_wb_vld  = r_wb_vld;
    assign bus.rf_wb_addr = r_wb_addr;
    assign bus.rf_wb_data = r_wb_data;

    // order encodes priority: flush over set over clear
    always_comb begin
        w_sb_nxt = r_sb;
        if (r_wb_vld) w_sb_nxt[r_wb_addr] = 1'b0;
        if (bus.idu_sb_set_vld && (bus.idu_sb_set_addr != '0)) w_sb_nxt[bus.idu_sb_set_addr] = 1'b1;
        if (bus.idu_sb_flush) w_sb_nxt = '0;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) r_sb <= '0;
        else       r_sb <= w_sb_nxt;
    end

    assign bus.sb_src1_busy = !rst_n && (bus.idu_src1_addr != '0) && r_sb[bus.idu_src1_addr];
    assign bus.sb_src2_busy = !rst_n && (bus.idu_src2_addr != '0) && r_sb[bus.idu_src2_addr];

endmodule

// File: tb/tb_rf_wb_arb.sv
// tb/tb_rf_wb_arb.sv - directed vector bench for rf_wb_arb
module tb_rf_wb_arb;

    logic clk;
    logic rst_n;

    rf_wb_arb_if #(.N_REQ(3), .XLEN(32), .AW(5)) bus ();

    rf_wb_arb dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  vld;
        logic [4:0]  a0, a1, a2;
        logic [31:0] d0, d1, d2;
        logic        set;
        logic [4:0]  sa;
        logic        fl;
        logic [4:0]  s1, s2;
        logic [2:0]  e_rdy;
        logic        e_wv;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_b1, e_b2;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] dv(input logic [4:0] a);
        return 32'h1000_0000 + {27'd0, a};
    endfunction

    task automatic add(input string nm, input logic [2:0] vld,
                       input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1,
                       input logic [4:0] a2, input logic [31:0] d2,
                       input logic set, input logic [4:0] sa, input logic fl,
                       input logic [4:0] s1, input logic [4:0] s2,
                       input logic [2:0] er, input logic ewv, input logic [4:0] ewa,
                       input logic [31:0] ewd, input logic eb1, input logic eb2);
        vec_t v;
        v.name = nm; v.vld = vld; v.a0 = a0; v.a1 = a1; v.a2 = a2;
        v.d0 = d0; v.d1 = d1; v.d2 = d2; v.set = set; v.sa = sa; v.fl = fl;
        v.s1 = s1; v.s2 = s2; v.e_rdy = er; v.e_wv = ewv; v.e_wa = ewa;
        v.e_wd = ewd; v.e_b1 = eb1; v.e_b2 = eb2;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.wb_req_vld      = v.vld;
        bus.wb_req_addr     = {v.a2, v.a1, v.a0};
        bus.wb_req_data     = {v.d2, v.d1, v.d0};
        bus.idu_sb_set_vld  = v.set;
        bus.idu_sb_set_addr = v.sa;
        bus.idu_sb_flush    = v.fl;
        bus.idu_src1_addr   = v.s1;
        bus.idu_src2_addr   = v.s2;
    endtask

    // requesters must hold vld until granted
    logic [2:0] pend;
    always @(posedge clk or posedge rst_n) begin
        if (rst_n) pend <= 3'b000;
        else begin
            assert ((pend & ~bus.wb_req_vld) == 3'b000)
                else $error("hold violation vld=%b pend=%b", bus.wb_req_vld, pend);
            pend <= bus.wb_req_vld & ~bus.wb_req_rdy;
        end
    end

    initial begin
        vec_t z;
        z = '{name: "z", default: '0};
        drive(z);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;

        //   name    vld a0 d0           a1 d1      a2 d2      set sa fl s1 s2 rdy wv wa  wd             b1 b2
        add("idle",  0,  0, 0,           0, 0,      0, 0,      0, 0, 0, 0, 0, 0, 0, 0,  0,             0, 0);
        add("rr1",   7, 10, dv(10),     11, dv(11), 12, dv(12), 0, 0, 0, 0, 0, 1, 0, 0,  0,             0, 0);
        add("rr2",   7, 13, dv(13),     11, dv(11), 12, dv(12), 0, 0, 0, 0, 0, 2, 1, 10, dv(10),        0, 0);
        add("rr3",   7, 13, dv(13),     14, dv(14), 12, dv(12), 0, 0, 0, 0, 0, 4, 1, 11, dv(11),        0, 0);
        add("rr4",   7, 13, dv(13),     14, dv(14), 15, dv(15), 0, 0, 0, 0, 0, 1, 1, 12, dv(12),        0, 0);
        add("rr5",   6,  0, 0,          14, dv(14), 15, dv(15), 0, 0, 0, 0, 0, 2, 1, 13, dv(13),        0, 0);
        add("rr6",   4,  0, 0,           0, 0,      15, dv(15), 0, 0, 0, 0, 0, 4, 1, 14, dv(14),        0, 0);
        add("rr7",   0,  0, 0,           0, 0,      0, 0,      0, 0, 0, 0, 0, 0, 1, 15, dv(15),        0, 0);
        add("sgl1",  1,  5, 32'hDEADBEEF,0, 0,      0, 0,      0, 0, 0, 0, 0, 1, 0, 0,  0,             0, 0);
        add("sgl2",  0,  0, 0,           0, 0,      0, 0,      0, 0, 0, 0, 0, 0, 1, 5,  32'hDEADBEEF,  0, 0);
        add("sb1",   0,  0, 0,           0, 0,      0, 0,      1, 7, 0, 7, 0, 0, 0, 0,  0,             0, 0);
        add("sb2",   4,  0, 0,           0, 0,      7, dv(7),  0, 0, 0, 7, 0, 4, 0, 0,  0,             1, 0);
        add("sb3",   0,  0, 0,           0, 0,      0, 0,      0, 0, 0, 7, 0, 0, 1, 7,  dv(7),         1, 0);
        add("sb4",   0,  0, 0,           0, 0,      0, 0,      0, 0, 0, 7, 0, 0, 0, 0,  0,             0, 0);
        add("col1",  0,  0, 0,           0, 0,      0, 0,      1, 9, 0, 9, 0, 0, 0, 0,  0,             0, 0);
        add("col2",  1,  9, dv(9),       0, 0,      0, 0,      0, 0, 0, 9, 0, 1, 0, 0,  0,             1, 0);
        add("col3",  0,  0, 0,           0, 0,      0, 0,      1, 9, 0, 9, 0, 0, 1, 9,  dv(9),         1, 0);
        add("x0a",   2,  0, 0,           0, dv(0),  0, 0,      1, 4, 0, 9, 9, 2, 0, 0,  0,             1, 1);
        add("x0b",   0,  0, 0,           0, 0,      0, 0,      1, 5, 0, 4, 0, 0, 0, 0,  0,             1, 0);
        add("fl1",   0,  0, 0,           0, 0,      0, 0,      1, 6, 0, 5, 0, 0, 0, 0,  0,             1, 0);
        add("fl2",   0,  0, 0,           0, 0,      0, 0,      1, 7, 0, 6, 9, 0, 0, 0,  0,             1, 1);
        add("fl3",   0,  0, 0,           0, 0,      0, 0,      1, 3, 1, 7, 4, 0, 0, 0,  0,             1, 1);
        add("fl4",   0,  0, 0,           0, 0,      0, 0,      0, 0, 0, 3, 7, 0, 0, 0,  0,             0, 0);
        add("fl5",   0,  0, 0,           0, 0,      0, 0,      0, 0, 0, 9, 4, 0, 0, 0,  0,             0, 0);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1 drive(vecs[i]);
            @(negedge clk);
            chk({vecs[i].name, " rdy"}, {29'd0, bus.wb_req_rdy}, {29'd0, vecs[i].e_rdy});
            chk({vecs[i].name, " wb_vld"}, {31'd0, bus.rf_wb_vld}, {31'd0, vecs[i].e_wv});
            if (vecs[i].e_wv) begin
                chk({vecs[i].name, " wb_addr"}, {27'd0, bus.rf_wb_addr}, {27'd0, vecs[i].e_wa});
                chk({vecs[i].name, " wb_data"}, bus.rf_wb_data, vecs[i].e_wd);
            end
            chk({vecs[i].name, " busy1"}, {31'd0, bus.sb_src1_busy}, {31'd0, vecs[i].e_b1});
            chk({vecs[i].name, " busy2"}, {31'd0, bus.sb_src2_busy}, {31'd0, vecs[i].e_b2});
        end

        // async reset mid-stream, rr_ptr is 2 here
        @(posedge clk);
        #1 begin
            z.vld = 3'b001; z.a0 = 5'd20; z.d0 = dv(20);
            z.set = 1'b1; z.sa = 5'd21; z.s1 = 5'd21;
            drive(z);
        end
        @(negedge clk);
        chk("rst pre rdy", {29'd0, bus.wb_req_rdy}, 32'd1);
        @(posedge clk);
        #1 bus.idu_sb_set_vld = 1'b0;
        chk("rst pre wb_vld", {31'd0, bus.rf_wb_vld}, 32'd1);
        chk("rst pre wb_addr", {27'd0, bus.rf_wb_addr}, 32'd20);
        chk("rst pre busy1", {31'd0, bus.sb_src1_busy}, 32'd1);
        #1 rst_n = 1'b1;
        #1;
        chk("rst rdy", {29'd0, bus.wb_req_rdy}, 32'd0);
        chk("rst wb_vld", {31'd0, bus.rf_wb_vld}, 32'd0);
        chk("rst wb_addr", {27'd0, bus.rf_wb_addr}, 32'd0);
        chk("rst wb_data", bus.rf_wb_data, 32'd0);
        chk("rst busy1", {31'd0, bus.sb_src1_busy}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("post rst rdy", {29'd0, bus.wb_req_rdy}, 32'd1);
        chk("post rst wb_vld", {31'd0, bus.rf_wb_vld}, 32'd0);
        chk("post rst busy1", {31'd0, bus.sb_src1_busy}, 32'd0);
        @(posedge clk);
        #1 bus.wb_req_vld = 3'b000;
        @(negedge clk);
        chk("post rst wb_vld2", {31'd0, bus.rf_wb_vld}, 32'd1);
        chk("post rst wb_addr2", {27'd0, bus.rf_wb_addr}, 32'd20);
        chk("post rst wb_data2", bus.rf_wb_data, dv(20));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
